fetch_unit: RTL and testbench

Instruction fetch front end for the RISC-V core. It consumes the program-counter value and drives a single-port instruction memory through a request/response handshake. It buffers returned instruction words with their PCs and presents them to decode through a valid/ready handshake. It sits between the PC/redirect logic and the decode stage, and is the reading side of the instruction-memory interface.

---
 rtl/fetch_unit_pkg.sv | 8 +
 rtl/fetch_unit_fifo.sv | 56 +++++
 rtl/fetch_unit.sv | 95 +++++++++
 tb/tb_fetch_unit.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_unit_pkg.sv
// fetch_unit_pkg: shared types and constants for the instruction fetch front end
package fetch_unit_pkg;
    typedef logic [31:0] int32_t;
    typedef int32_t addr_t;
    typedef logic [31:0] inst_t;
    typedef enum logic [1:0] {REQ, WAIT, DRAIN} fetch_state_e;
    localparam int unsigned INST_BYTES = 4;
endpackage

// File: rtl/fetch_unit_fifo.sv
// fetch_fifo: synchronous {pc, inst} buffer; flush wins over push, output zeroed when empty
module fetch_fifo
    import fetch_unit_pkg::*;
#(
    parameter int DEPTH = 2,
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_push,
    input  logic [31:0]   i_pc,
    input  logic [31:0]   i_data,
    input  logic          i_pop,
    input  logic          i_flush,
    output logic          o_empty,
    output logic [CW-1:0] o_count,
    output logic [31:0]   o_pc,
    output logic [31:0]   o_data
);
    addr_t         r_pc_mem   [DEPTH];
    inst_t         r_data_mem [DEPTH];
    logic [PW-1:0] r_wr, r_rd;
    logic [CW-1:0] r_count;
    logic          w_push, w_pop;

    function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign w_pop   = i_pop && (r_count != '0);
    assign w_push  = i_push && ((r_count < CW'(DEPTH)) || w_pop);
    assign o_empty = (r_count == '0);
    assign o_count = r_count;
    assign o_pc    = o_empty ? '0 : r_pc_mem[r_rd];
    assign o_data  = o_empty ? '0 : r_data_mem[r_rd];

    always_ff @(posedge clk) begin
        if (!rst || i_flush) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
        end else begin
            r_wr    <= w_push ? nxt(r_wr) : r_wr;
            r_rd    <= w_pop ? nxt(r_rd) : r_rd;
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_pc_mem[r_wr]   <= i_pc;
            r_data_mem[r_wr] <= i_data;
        end
    end
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: single-outstanding instruction fetch with buffered decode handshake.
// FETCH_ALIGN_CHECK_EN enables the misaligned-redirect fault; otherwise fault is 0.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int          DEPTH    = 2,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_redirect_valid,
    input  logic [31:0] i_redirect_pc,
    output logic        o_mem_req_valid,
    input  logic        i_mem_req_ready,
    output logic [31:0] o_mem_req_addr,
    input  logic        i_mem_rsp_valid,
    input  logic [31:0] i_mem_rsp_data,
    output logic        o_inst_valid,
    input  logic        i_inst_ready,
    output logic [31:0] o_inst_pc,
    output logic [31:0] o_inst_data,
    output logic        o_fault
);
    localparam int CW = $clog2(DEPTH + 1);

    fetch_state_e  r_state, w_state_nxt;
    addr_t         r_fetch_pc, w_pc_nxt, w_redir_pc;
    logic          r_run, w_fault, w_accept, w_push, w_empty;
    logic [CW-1:0] w_count;

    assign w_redir_pc      = i_redirect_pc & ~addr_t'(INST_BYTES - 1);
    // r_run keeps requests off through the reset cycle using registered state only
    assign o_mem_req_valid = r_run && (r_state == REQ) && (w_count < CW'(DEPTH)) && !w_fault;
    assign o_mem_req_addr  = r_fetch_pc;
    assign w_accept        = o_mem_req_valid && i_mem_req_ready;
    assign w_push          = !i_redirect_valid && (r_state == WAIT) && i_mem_rsp_valid;
    assign o_inst_valid    = !w_empty;
    assign o_fault         = w_fault;

    fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_pc    (r_fetch_pc - addr_t'(INST_BYTES)),
        .i_data  (i_mem_rsp_data),
        .i_pop   (o_inst_valid && i_inst_ready),
        .i_flush (i_redirect_valid),
        .o_empty (w_empty),
        .o_count (w_count),
        .o_pc    (o_inst_pc),
        .o_data  (o_inst_data)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_fetch_pc;
        if (i_redirect_valid) begin
            w_pc_nxt    = w_redir_pc;
            w_state_nxt = (w_accept || (r_state != REQ && !i_mem_rsp_valid)) ? DRAIN : REQ;
        end else if (r_state == REQ) begin
            w_state_nxt = w_accept ? WAIT : REQ;
            w_pc_nxt    = w_accept ? r_fetch_pc + addr_t'(INST_BYTES) : r_fetch_pc;
        end else begin
            w_state_nxt = i_mem_rsp_valid ? REQ : r_state;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state    <= REQ;
            r_fetch_pc <= RESET_PC & ~addr_t'(INST_BYTES - 1);
            r_run      <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_fetch_pc <= w_pc_nxt;
            r_run      <= 1'b1;
        end
    end

`ifdef FETCH_ALIGN_CHECK_EN
    logic r_fault;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_fault <= 1'b0;
        end else if (i_redirect_valid) begin
            r_fault <= (i_redirect_pc[1:0] != 2'b00);
        end
    end

    assign w_fault = r_fault;
`else
    assign w_fault = 1'b0;
`endif
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: randomized fetch traffic against a stream-level reference model and scoreboard
module tb_fetch_unit;
    localparam int          DEPTH    = 2;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] pc;
        int unsigned ep;
    } req_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] data;
    } ent_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_redirect_valid, i_mem_req_ready, i_mem_rsp_valid, i_inst_ready;
    logic [31:0] i_redirect_pc, i_mem_rsp_data;
    logic        o_mem_req_valid, o_inst_valid, o_fault;
    logic [31:0] o_mem_req_addr, o_inst_pc, o_inst_data;

    ent_t        exp_q[$];
    req_t        out_q[$];
    ent_t        m_e;
    req_t        m_r;
    logic [31:0] exp_pc = RESET_PC;
    int unsigned epoch = 0;
    logic        m_fault = 1'b0, running = 1'b0, model_ok = 1'b0;
    int          checks = 0, errors = 0, n_hs = 0;

    int          rdy_pct, ird_pct, lat_max, redir_pct, wcnt;
    logic        redir_on_rsp = 1'b0, force_redir = 1'b0, busy = 1'b0;
    logic [31:0] force_pc;

    fetch_unit #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .clk              (clk),
        .rst              (rst),
        .i_redirect_valid (i_redirect_valid),
        .i_redirect_pc    (i_redirect_pc),
        .o_mem_req_valid  (o_mem_req_valid),
        .i_mem_req_ready  (i_mem_req_ready),
        .o_mem_req_addr   (o_mem_req_addr),
        .i_mem_rsp_valid  (i_mem_rsp_valid),
        .i_mem_rsp_data   (i_mem_rsp_data),
        .o_inst_valid     (o_inst_valid),
        .i_inst_ready     (i_inst_ready),
        .o_inst_pc        (o_inst_pc),
        .o_inst_data      (o_inst_data),
        .o_fault          (o_fault)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
    endfunction

    function automatic logic [31:0] rand_target();
        logic [31:0] t;
        t = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFE0 | ($urandom & 32'h1C)) : ($urandom & 32'h0000_0FFC);
        if ($urandom_range(0, 7) == 0) t[1:0] = 2'($urandom_range(1, 3));
        return t;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: compares DUT outputs mid-cycle against the model state and pops on handshakes
    always @(negedge clk) begin
        if (model_ok) begin
            check("inst_valid", 32'(o_inst_valid), 32'(exp_q.size() != 0));
            check("mem_req_valid", 32'(o_mem_req_valid),
                  32'(running && out_q.size() == 0 && exp_q.size() < DEPTH && !m_fault));
            check("fault", 32'(o_fault), 32'(m_fault));
            if (o_mem_req_valid) check("mem_req_addr", o_mem_req_addr, exp_pc);
            if (!running) begin
                check("reset_inst_pc", o_inst_pc, 32'h0);
                check("reset_inst_data", o_inst_data, 32'h0);
            end
            if (rst && o_inst_valid && i_inst_ready) begin
                n_hs++;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL inst_extra: got pc %h expected no instruction at %0t", o_inst_pc, $time);
                end else begin
                    m_e = exp_q.pop_front();
                    check("inst_pc", o_inst_pc, m_e.pc);
                    check("inst_data", o_inst_data, m_e.data);
                end
            end
        end
    end

    // Reference model: the instruction stream is sequential from the last redirect target;
    // responses to requests issued before a redirect (older epoch) never reach decode.
    always begin
        @(negedge clk);
        #1;
        if (!rst) begin
            exp_q.delete();
            out_q.delete();
            exp_pc   = RESET_PC;
            m_fault  = 1'b0;
            model_ok = 1'b1;
        end else if (model_ok) begin
            if (o_mem_req_valid && i_mem_req_ready) begin
                out_q.push_back('{o_mem_req_addr, exp_pc, epoch});
                exp_pc = exp_pc + 32'd4;
            end
            if (i_mem_rsp_valid && out_q.size() != 0) begin
                m_r = out_q.pop_front();
                if (m_r.ep == epoch && !i_redirect_valid) exp_q.push_back('{m_r.pc, mem_word(m_r.pc)});
            end
            if (i_redirect_valid) begin
                exp_q.delete();
                epoch++;
                exp_pc = {i_redirect_pc[31:2], 2'b00};
`ifdef FETCH_ALIGN_CHECK_EN
                m_fault = (i_redirect_pc[1:0] != 2'b00);
`endif
            end
        end
        running = rst;
    end

    task automatic step();
        @(posedge clk);
        #1;
        i_mem_rsp_valid = 1'b0;
        if (out_q.size() == 0) begin
            busy = 1'b0;
        end else if (rst) begin
            if (!busy) begin
                busy = 1'b1;
                wcnt = int'($urandom_range(0, lat_max - 1));
            end
            if (wcnt == 0) begin
                i_mem_rsp_valid = 1'b1;
                i_mem_rsp_data  = mem_word(out_q[0].addr);
                busy            = 1'b0;
            end else begin
                wcnt--;
            end
        end
        i_mem_req_ready  = (int'($urandom_range(0, 99)) < rdy_pct);
        i_inst_ready     = (int'($urandom_range(0, 99)) < ird_pct);
        i_redirect_valid = 1'b0;
        if (force_redir) begin
            i_redirect_valid = 1'b1;
            i_redirect_pc    = force_pc;
            force_redir      = 1'b0;
        end else if (redir_on_rsp && i_mem_rsp_valid && o_inst_valid) begin
            i_redirect_valid = 1'b1;
            i_inst_ready     = 1'b1;
            i_redirect_pc    = 32'h300;
        end else if (int'($urandom_range(0, 99)) < redir_pct) begin
            i_redirect_valid = 1'b1;
            i_redirect_pc    = rand_target();
        end
    endtask

    task automatic run(input int n);
        repeat (n) step();
    endtask

    task automatic redirect_to(input logic [31:0] pc, input int n);
        force_pc    = pc;
        force_redir = 1'b1;
        run(n);
    endtask

    initial begin
        rst              = 1'b0;
        i_redirect_valid = 1'b0;
        i_redirect_pc    = '0;
        i_mem_req_ready  = 1'b0;
        i_mem_rsp_valid  = 1'b0;
        i_mem_rsp_data   = '0;
        i_inst_ready     = 1'b0;
        force_pc         = '0;
        rdy_pct          = 100;
        ird_pct          = 100;
        lat_max          = 1;
        redir_pct        = 0;
        run(3);
        rst = 1'b1;
        run(30);
        ird_pct = 0;
        run(12);
        ird_pct = 100;
        run(10);
        lat_max = 3;
        for (int k = 0; k < 20 && out_q.size() == 0; k++) step();
        check("wait_for_request", 32'(out_q.size() != 0), 32'd1);
        redirect_to(32'h100, 20);
        lat_max      = 1;
        ird_pct      = 0;
        redir_on_rsp = 1'b1;
        run(10);
        redir_on_rsp = 1'b0;
        ird_pct      = 100;
        run(10);
        redirect_to(32'hFFFF_FFF4, 20);
        redirect_to(32'h102, 10);
        redirect_to(32'h200, 12);
        rdy_pct   = 75;
        ird_pct   = 60;
        lat_max   = 3;
        redir_pct = 6;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 399) == 0) begin
                rst = 1'b0;
                run(2);
                rst = 1'b1;
            end
            step();
        end
        rdy_pct   = 100;
        ird_pct   = 100;
        redir_pct = 0;
        run(20);
        check("handshake_count", 32'(n_hs > 100), 32'd1);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
